// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } if_state_e;

    // Source selection for the next PC value.
    typedef enum logic [1:0] {
        PC_KEEP     = 2'd0,
        PC_START    = 2'd1,
        PC_REDIRECT = 2'd2,
        PC_STEP     = 2'd3
    } pc_sel_e;

    localparam logic [31:0] NOP_INSTR      = 32'h0;
    localparam int          DEFAULT_PC_INC = 4;

endpackage

// File: rtl/if_pc_gen.sv
// PC register with boot/redirect/sequential next-PC selection.
// The sequential adder wraps modulo 2^ADDR_W; no alignment is enforced.
module if_pc_gen
    import if_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int PC_INC = DEFAULT_PC_INC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_e           sel,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus
);

    logic [ADDR_W-1:0] pc_next;

    assign pc_plus = pc + ADDR_W'(PC_INC);

    always_comb begin
        // NOTE: default assigned first so no path leaves pc_next unassigned (no latch).
        pc_next = pc;
        unique case (sel)
            PC_KEEP:     pc_next = pc;
            PC_START:    pc_next = start_pc;
            PC_REDIRECT: pc_next = redirect_pc;
            PC_STEP:     pc_next = pc_plus;
        endcase
    end

    // NOTE: registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetch FSM, hold buffer, drain tracking and IF/ID register.
// Optional performance counters are compiled in when IF_PERF_CNT_EN is defined.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int PC_INC  = DEFAULT_PC_INC
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [ADDR_W-1:0]  startPC,
    output logic               imemReq,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirectPC,
    output logic               ifidValid,
    output logic [INSTR_W-1:0] ifidInstr,
    output logic [ADDR_W-1:0]  ifidPC,
    output logic [ADDR_W-1:0]  ifidPCPlus4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetchCount,
    output logic [31:0]        bubbleCount
`endif
);

    if_state_e          state;
    if_state_e          state_next;
    pc_sel_e            pc_sel;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus;

    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc;
    logic [ADDR_W-1:0]  hold_pc_plus;
    logic [ADDR_W-1:0]  drain_addr;

    logic can_accept;
    logic consume;
    logic load_mem;
    logic load_hold;
    logic clear_valid;
    logic capture_hold;
    logic capture_drain;

    if_pc_gen #(
        .ADDR_W (ADDR_W),
        .PC_INC (PC_INC)
    ) u_pc_gen (
        .clk         (CLK),
        .rst_n       (Reset_L),
        .sel         (pc_sel),
        .start_pc    (startPC),
        .redirect_pc (redirectPC),
        .pc          (pc),
        .pc_plus     (pc_plus)
    );

    assign consume    = ifidValid && !stall;
    assign can_accept = !ifidValid || !stall;

    // DRAIN keeps presenting the abandoned address until memory acknowledges it.
    assign imemReq  = (state == FETCH) || (state == DRAIN);
    assign imemAddr = (state == DRAIN) ? drain_addr : pc;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_sel        = PC_KEEP;
        load_mem      = 1'b0;
        load_hold     = 1'b0;
        clear_valid   = 1'b0;
        capture_hold  = 1'b0;
        capture_drain = 1'b0;
        unique case (state)
            BOOT: begin
                pc_sel     = PC_START;
                state_next = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    clear_valid = 1'b1;
                    pc_sel      = PC_REDIRECT;
                    if (!imemAck) begin
                        capture_drain = 1'b1;
                        state_next    = DRAIN;
                    end
                end else if (imemAck) begin
                    pc_sel = PC_STEP;
                    if (can_accept) begin
                        load_mem = 1'b1;
                    end else begin
                        capture_hold = 1'b1;
                        state_next   = HOLD;
                    end
                end else if (consume) begin
                    clear_valid = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    clear_valid = 1'b1;
                    pc_sel      = PC_REDIRECT;
                    state_next  = FETCH;
                end else if (!stall) begin
                    load_hold  = 1'b1;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    clear_valid = 1'b1;
                    pc_sel      = PC_REDIRECT;
                end
                if (imemAck) begin
                    state_next = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            hold_instr   <= INSTR_W'(NOP_INSTR);
            hold_pc      <= '0;
            hold_pc_plus <= '0;
            drain_addr   <= '0;
        end else begin
            if (capture_hold) begin
                hold_instr   <= imemData;
                hold_pc      <= pc;
                hold_pc_plus <= pc_plus;
            end
            if (capture_drain) begin
                drain_addr <= pc;
            end
        end
    end

    // Contents stay frozen unless a load or a flush/consume explicitly touches them.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            ifidValid   <= 1'b0;
            ifidInstr   <= INSTR_W'(NOP_INSTR);
            ifidPC      <= '0;
            ifidPCPlus4 <= '0;
        end else if (load_mem) begin
            ifidValid   <= 1'b1;
            ifidInstr   <= imemData;
            ifidPC      <= pc;
            ifidPCPlus4 <= pc_plus;
        end else if (load_hold) begin
            ifidValid   <= 1'b1;
            ifidInstr   <= hold_instr;
            ifidPC      <= hold_pc;
            ifidPCPlus4 <= hold_pc_plus;
        end else if (clear_valid) begin
            ifidValid <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            fetchCount  <= '0;
            bubbleCount <= '0;
        end else begin
            if (load_mem || load_hold) begin
                fetchCount <= fetchCount + 32'd1;
            end
            if ((state != BOOT) && !ifidValid) begin
                bubbleCount <= bubbleCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: program-order stream model plus literal checkpoints.
module tb_if_fetch_stage;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [31:0] startPC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        ifidValid;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPC;
    logic [31:0] ifidPCPlus4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCount;
    logic [31:0] bubbleCount;
`endif

    if_fetch_stage dut (
        .CLK         (CLK),
        .Reset_L     (Reset_L),
        .startPC     (startPC),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemAck     (imemAck),
        .imemData    (imemData),
        .stall       (stall),
        .redirect    (redirect),
        .redirectPC  (redirectPC),
        .ifidValid   (ifidValid),
        .ifidInstr   (ifidInstr),
        .ifidPC      (ifidPC),
        .ifidPCPlus4 (ifidPCPlus4)
`ifdef IF_PERF_CNT_EN
        ,
        .fetchCount  (fetchCount),
        .bubbleCount (bubbleCount)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory model: acks once a request has waited lat cycles; content is a hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    int unsigned lat = 0;
    int unsigned wait_cnt;

    assign imemAck  = imemReq && (wait_cnt >= lat);
    assign imemData = mem_word(imemAddr);

    always @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            wait_cnt <= 0;
        end else if (imemReq && !imemAck) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: every instruction ID takes must be the next one in program order.
    logic        boot_pending = 1'b1;
    logic [31:0] exp_pc = '0;
    logic        freeze_pending = 1'b0;
    logic        flush_pending = 1'b0;
    logic        req_pending = 1'b0;
    logic [31:0] snap_instr, snap_pc, snap_pc4, prev_addr;

    always @(negedge CLK) begin
        if (!Reset_L) begin
            check("rst_req",   imemReq,     32'd0);
            check("rst_addr",  imemAddr,    32'd0);
            check("rst_valid", ifidValid,   32'd0);
            check("rst_instr", ifidInstr,   32'd0);
            check("rst_pc",    ifidPC,      32'd0);
            check("rst_pc4",   ifidPCPlus4, 32'd0);
            boot_pending   = 1'b1;
            freeze_pending = 1'b0;
            flush_pending  = 1'b0;
            req_pending    = 1'b0;
        end else begin
            if (freeze_pending) begin
                check("frozen_instr", ifidInstr,   snap_instr);
                check("frozen_pc",    ifidPC,      snap_pc);
                check("frozen_pc4",   ifidPCPlus4, snap_pc4);
            end
            if (flush_pending) check("flush_valid", ifidValid, 32'd0);
            if (req_pending) begin
                check("req_held",    imemReq,  32'd1);
                check("addr_stable", imemAddr, prev_addr);
            end
            if (ifidValid) check("pc4_rel", ifidPCPlus4, ifidPC + 32'd4);
            if (boot_pending) begin
                check("boot_no_req", imemReq, 32'd0);
                exp_pc         = startPC;
                boot_pending   = 1'b0;
                freeze_pending = 1'b0;
                flush_pending  = 1'b0;
            end else begin
                if (ifidValid && !stall) begin
                    check("stream_pc",    ifidPC,      exp_pc);
                    check("stream_instr", ifidInstr,   mem_word(exp_pc));
                    check("stream_pc4",   ifidPCPlus4, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                end
                if (redirect) exp_pc = redirectPC;
                freeze_pending = ifidValid && stall && !redirect;
                flush_pending  = redirect;
            end
            snap_instr  = ifidInstr;
            snap_pc     = ifidPC;
            snap_pc4    = ifidPCPlus4;
            req_pending = imemReq && !imemAck;
            prev_addr   = imemAddr;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    initial begin
        Reset_L    = 1'b1;
        startPC    = 32'h60;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPC = '0;
        #1 Reset_L = 1'b0;
        tick(2);
        check("init_req",   imemReq,   32'd0);
        check("init_valid", ifidValid, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("init_fetch_cnt",  fetchCount,  32'd0);
        check("init_bubble_cnt", bubbleCount, 32'd0);
`endif
        Reset_L = 1'b1;

        // Boot at 0x60, zero-latency memory.
        tick;
        check("boot_addr0",  imemAddr,  32'h60);
        check("boot_req",    imemReq,   32'd1);
        check("boot_valid0", ifidValid, 32'd0);
        tick;
        check("boot_addr1", imemAddr,    32'h64);
        check("boot_valid", ifidValid,   32'd1);
        check("boot_pc",    ifidPC,      32'h60);
        check("boot_pc4",   ifidPCPlus4, 32'h64);
        check("boot_instr", ifidInstr,   mem_word(32'h60));
        tick;
        check("boot_addr2", imemAddr, 32'h68);
        check("boot_pc1",   ifidPC,   32'h64);

        // Stall three cycles while 0x68 is acked into the hold buffer.
        stall = 1'b1;
        tick;
        check("hold_req", imemReq, 32'd0);
        check("hold_pc",  ifidPC,  32'h64);
        tick(2);
        check("hold_req3", imemReq, 32'd0);
        check("hold_pc3",  ifidPC,  32'h64);
        stall = 1'b0;
        tick;
        check("unhold_pc",    ifidPC,    32'h68);
        check("unhold_valid", ifidValid, 32'd1);
        check("resume_addr",  imemAddr,  32'h6C);
        tick;
        check("resume_pc", ifidPC, 32'h6C);

        // Redirect coinciding with an ack, then one-wait-state memory.
        redirect   = 1'b1;
        redirectPC = 32'hA0;
        tick;
        redirect = 1'b0;
        lat      = 1;
        check("rd_ack_addr",  imemAddr,  32'hA0);
        check("rd_ack_valid", ifidValid, 32'd0);
        tick;
        check("lat2_addr_hold", imemAddr,  32'hA0);
        check("lat2_valid0",    ifidValid, 32'd0);
        tick;
        check("lat2_valid1", ifidValid, 32'd1);
        check("lat2_pc",     ifidPC,    32'hA0);
        check("lat2_addr",   imemAddr,  32'hA4);
        tick;
        check("lat2_valid2", ifidValid, 32'd0);
        tick;
        check("lat2_valid3", ifidValid, 32'd1);
        check("lat2_pc2",    ifidPC,    32'hA4);

        // Redirect to 0x100 while a slow request to 0x10 is outstanding.
        lat        = 0;
        redirect   = 1'b1;
        redirectPC = 32'h10;
        tick;
        redirect = 1'b0;
        lat      = 3;
        check("slow_addr", imemAddr, 32'h10);
        tick;
        redirect   = 1'b1;
        redirectPC = 32'h100;
        tick;
        redirect = 1'b0;
        check("drain_addr",  imemAddr,  32'h10);
        check("drain_req",   imemReq,   32'd1);
        check("drain_valid", ifidValid, 32'd0);
        for (int i = 0; i < 12 && !(imemReq && imemAddr == 32'h100); i++) tick;
        check("refetch_addr",  imemAddr,  32'h100);
        check("refetch_valid", ifidValid, 32'd0);
        for (int i = 0; i < 12 && !ifidValid; i++) tick;
        check("target_valid", ifidValid, 32'd1);
        check("target_pc",    ifidPC,    32'h100);

        // Wrap-around sequencing from near the top of the address space.
        lat = 0;
        tick(2);
        redirect   = 1'b1;
        redirectPC = 32'hFFFF_FFF8;
        tick;
        redirect = 1'b0;
        check("wrap_addr0",  imemAddr,  32'hFFFF_FFF8);
        check("wrap_valid0", ifidValid, 32'd0);
        tick;
        check("wrap_pc0",   ifidPC,   32'hFFFF_FFF8);
        check("wrap_addr1", imemAddr, 32'hFFFF_FFFC);
        tick;
        check("wrap_pc1",   ifidPC,      32'hFFFF_FFFC);
        check("wrap_pc4",   ifidPCPlus4, 32'h0);
        check("wrap_addr2", imemAddr,    32'h0);
        tick;
        check("wrap_pc2", ifidPC, 32'h0);

        // Asynchronous reset in the middle of HOLD, then reboot from a new start PC.
        stall = 1'b1;
        tick;
        check("pre_rst_hold", imemReq, 32'd0);
        #1 Reset_L = 1'b0;
        #1;
        check("async_req",   imemReq,     32'd0);
        check("async_addr",  imemAddr,    32'd0);
        check("async_valid", ifidValid,   32'd0);
        check("async_instr", ifidInstr,   32'd0);
        check("async_pc",    ifidPC,      32'd0);
        check("async_pc4",   ifidPCPlus4, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("async_fetch_cnt",  fetchCount,  32'd0);
        check("async_bubble_cnt", bubbleCount, 32'd0);
`endif
        startPC = 32'h200;
        stall   = 1'b0;
        tick(2);
        Reset_L = 1'b1;
        tick;
        check("reboot_addr", imemAddr, 32'h200);
        tick(3);
        check("reboot_pc",    ifidPC,    32'h208);
        check("reboot_valid", ifidValid, 32'd1);
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt3",  fetchCount,  32'd3);
        check("bubble_cnt1", bubbleCount, 32'd1);
`endif
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of PipelinedProc: owns the PC, drives the instruction-memory request interface and loads the IF/ID pipeline register.
- Boots from `startPC` after reset, sequences by 4, obeys ID-stage stall and EX-stage redirect (branch/jump).
- Tolerates variable instruction-memory latency via a req/ack handshake and a one-entry hold buffer.

Parameters:
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- PC_INC, 4, sequential PC increment in bytes

Ports:
- CLK  in  1  clock, rising edge
- Reset_L  in  1  asynchronous active-low reset
- startPC  in  ADDR_W  boot PC, sampled on first rising edge after Reset_L deasserts
- imemReq  out  1  fetch request; held until imemAck
- imemAddr  out  ADDR_W  fetch address; stable while imemReq=1 and no ack
- imemAck  in  1  imemData valid this cycle for current request; may be same cycle as request
- imemData  in  INSTR_W  fetched instruction
- stall  in  1  ID does not consume IF/ID contents this cycle
- redirect  in  1  branch/jump taken; flush and refetch
- redirectPC  in  ADDR_W  target PC when redirect=1
- ifidValid  out  1  IF/ID holds a live instruction
- ifidInstr  out  INSTR_W  instruction
- ifidPC  out  ADDR_W  PC of ifidInstr
- ifidPCPlus4  out  ADDR_W  ifidPC+PC_INC

Behaviour:
- Reset (async, Reset_L=0): state=BOOT; pc, hold, and all outputs 0. ifidInstr=0 (NOP).
- Consume rule: ID takes IF/ID when ifidValid=1 and stall=0. IF/ID can accept when ifidValid=0 or stall=0.
- States:
  - BOOT: imemReq=0; next edge pc<=startPC, go to FETCH.
  - FETCH: imemReq=1, imemAddr=pc.
  - HOLD: imemReq=0; the fetched word sits in the hold register.
  - DRAIN: imemReq=1, imemAddr=old pc; waits out a request that was abandoned by a redirect.
- Redirect has top priority in every state except BOOT:
  - ifidValid<=0; hold discarded; pc<=redirectPC.
  - If a request is outstanding (FETCH with imemAck=0), go to DRAIN; otherwise go to FETCH.
  - A redirect in the same cycle as imemAck discards that data and goes to FETCH.
- FETCH, imemAck=1, can accept: ifid<={imemData,pc,pc+PC_INC}, ifidValid<=1, pc<=pc+PC_INC, stay in FETCH. Back-to-back acks give one instruction per cycle.
- FETCH, imemAck=1, cannot accept: hold<={imemData,pc}, pc<=pc+PC_INC, go to HOLD.
- FETCH, imemAck=0: if ID consumes, ifidValid<=0.
- HOLD, stall=0: ifid<=hold, ifidValid<=1, go to FETCH.
- DRAIN, imemAck=1: drop data, go to FETCH (pc already holds the target). A second redirect while in DRAIN updates pc and stays in DRAIN.
- IF/ID contents are frozen while stall=1 and no redirect.
- Latency: instruction visible on ifid* the edge after its ack.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC+4 wraps to 0. No alignment check.
- Reset asserted mid-request abandons everything immediately. The memory must tolerate a dropped request.

Optional Feature:
- IF_PERF_CNT_EN defined:
  - Adds outputs fetchCount[31:0] (increments per instruction written into IF/ID) and bubbleCount[31:0] (increments per cycle with ifidValid=0 after BOOT).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package if_pkg holds:
  - state enum BOOT=2'd0, FETCH=2'd1, HOLD=2'd2, DRAIN=2'd3
  - NOP_INSTR=32'h0
  - default PC_INC
- One sub-module, if_pc_gen, holds the PC register, next-PC mux (startPC/redirectPC/pc+PC_INC/hold) and wrap adder. The FSM and IF/ID register stay in the top.

Test Plan:
- Boot at startPC=0x60 with 0-latency ack and stall=0: imemAddr 0x60,0x64,0x68 on consecutive cycles; ifidPC 0x60 appears one edge after the first ack; ifidPCPlus4=0x64.
- Latency 2 (ack on 2nd request cycle): imemAddr 0xA0 held two cycles; ifidValid toggles 1,0 pattern; no duplicate or lost PC.
- stall=1 for 3 cycles with ack arriving: ifid frozen at 0x64; state HOLD with 0x68 buffered, imemReq=0; after stall drops, ifidPC=0x68, then fetch resumes at 0x6C.
- redirect to 0x100 while a latency-3 request to 0x10 is outstanding: the 0x10 data is discarded (never valid on ifid); next imemAddr=0x100; ifidValid=0 until its ack.
- Simultaneous redirect+imemAck, and pc=0xFFFFFFFC sequencing: data dropped, next fetch at redirectPC; wrap produces imemAddr 0x0.
- Reset_L pulsed low mid-HOLD: all outputs 0 asynchronously; reboots from new startPC. With IF_PERF_CNT_EN, counters read 0 after reset and fetchCount=3 after three delivered instructions.
